// File: rtl/qr_seq_divider.sv
// qr_seq_divider: multi-cycle restoring fixed-point divider for the QR datapath.
// One division in flight. Signed/unsigned selectable per request. Resolves
// BPC quotient bits per cycle. Saturates the quotient and flags
// divide-by-zero and overflow.
module qr_seq_divider #(
  parameter int DW_A = 27,
  parameter int DW_B = 27,
  parameter int QW   = 16,
  parameter int BPC  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [DW_A-1:0] i_a,
  input  logic [DW_B-1:0] i_b,
  output logic            o_busy,
  output logic            o_fin,
  output logic [QW-1:0]   o_result,
  output logic            o_div0,
  output logic            o_ovf
);

  localparam int AW   = DW_A + 1;              // |most-negative a| fits
  localparam int BW   = DW_B + 1;
  localparam int DSW  = DW_B + QW + 1;         // |b| << QW
  localparam int CW   = ((AW > DSW) ? AW : DSW) + 2;  // headroom for 3x divisor
  localparam int NIT  = QW / BPC;
  localparam int CNTW = $clog2(NIT + 1);

  localparam logic [QW-1:0] SMAX = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] SMIN = {1'b1, {(QW-1){1'b0}}};
  localparam logic [QW-1:0] UMAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_POST} state_t;

  state_t state, state_nx;

  logic [DW_A-1:0] a_q;
  logic [DW_B-1:0] b_q;
  logic            sgn_q, neg_q, aneg_q, div0_q, povf_q;
  logic [CW-1:0]   rem, dsh;
  logic [QW-1:0]   quo;
  logic [CNTW-1:0] cnt;

  // operand magnitudes and early-exit decisions, used in PREP
  logic           a_neg, b_neg, b_zero, a_big;
  logic [AW-1:0]  a_ext, a_mag;
  logic [BW-1:0]  b_ext, b_mag;

  assign a_neg  = sgn_q & a_q[DW_A-1];
  assign b_neg  = sgn_q & b_q[DW_B-1];
  assign a_ext  = {a_neg, a_q};
  assign b_ext  = {b_neg, b_q};
  assign a_mag  = a_neg ? -a_ext : a_ext;
  assign b_mag  = b_neg ? -b_ext : b_ext;
  assign b_zero = (b_mag == '0);
  assign a_big  = CW'(a_mag) >= (CW'(b_mag) << QW);

  // one restoring step: pick the largest multiple of the shifted divisor
  logic [CW-1:0]  d1, d2, d3, rem_nx;
  logic [BPC-1:0] digit;

  assign d1 = dsh;
  assign d2 = dsh << 1;
  assign d3 = d1 + d2;

  // trial subtraction for the current quotient digit
  always_comb begin
    digit  = '0;
    rem_nx = rem;
    if (BPC == 2) begin
      if (rem >= d3) begin
        digit  = BPC'(2'd3);
        rem_nx = rem - d3;
      end else if (rem >= d2) begin
        digit  = BPC'(2'd2);
        rem_nx = rem - d2;
      end else if (rem >= d1) begin
        digit  = BPC'(2'd1);
        rem_nx = rem - d1;
      end
    end else if (rem >= d1) begin
      digit  = BPC'(1'b1);
      rem_nx = rem - d1;
    end
  end

  // sign application, saturation and forced extremes for flagged cases
  logic [QW-1:0] res_nx;
  logic          ovf_nx;

  always_comb begin
    res_nx = quo;
    ovf_nx = 1'b0;
    if (div0_q) begin
      res_nx = !sgn_q ? UMAX : (aneg_q ? SMIN : SMAX);
    end else if (povf_q) begin
      res_nx = !sgn_q ? UMAX : (neg_q ? SMIN : SMAX);
      ovf_nx = 1'b1;
    end else if (sgn_q) begin
      if (neg_q) begin
        if (quo > SMIN) begin
          res_nx = SMIN;
          ovf_nx = 1'b1;
        end else begin
          res_nx = -quo;
        end
      end else if (quo > SMAX) begin
        res_nx = SMAX;
        ovf_nx = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_start) state_nx = S_PREP;
      S_PREP:  state_nx = (b_zero || a_big) ? S_POST : S_ITER;
      S_ITER:  if (cnt == '0) state_nx = S_POST;
      S_POST:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (state != S_IDLE);
  end

  // operand latch, setup and iteration datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      neg_q  <= 1'b0;
      aneg_q <= 1'b0;
      div0_q <= 1'b0;
      povf_q <= 1'b0;
      rem    <= '0;
      dsh    <= '0;
      quo    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          a_q   <= i_a;
          b_q   <= i_b;
          sgn_q <= i_signed;
        end
        S_PREP: begin
          neg_q  <= a_neg ^ b_neg;
          aneg_q <= a_neg;
          div0_q <= b_zero;
          povf_q <= !b_zero && a_big;
          rem    <= CW'(a_mag);
          dsh    <= CW'(b_mag) << (QW - BPC);
          quo    <= '0;
          cnt    <= CNTW'(NIT - 1);
        end
        S_ITER: begin
          rem <= rem_nx;
          dsh <= dsh >> BPC;
          quo <= {quo[QW-BPC-1:0], digit};
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // result registers; held until the next POST
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fin    <= 1'b0;
      o_result <= '0;
      o_div0   <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      o_fin <= (state == S_POST);
      if (state == S_POST) begin
        o_result <= res_nx;
        o_div0   <= div0_q;
        o_ovf    <= ovf_nx;
      end
    end
  end

endmodule

// File: tb/tb_qr_seq_divider.sv
// Bench for qr_seq_divider: BPC=1 and BPC=2 instances share stimulus.
module tb_qr_seq_divider;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_signed = 1'b0;
  logic [26:0] i_a = '0;
  logic [26:0] i_b = '0;

  logic        busy1, fin1, div0_1, ovf1;
  logic [15:0] res1;
  logic        busy2, fin2, div0_2, ovf2;
  logic [15:0] res2;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  qr_seq_divider #(.DW_A(27), .DW_B(27), .QW(16), .BPC(1)) u1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_signed(i_signed),
    .i_a(i_a), .i_b(i_b), .o_busy(busy1), .o_fin(fin1), .o_result(res1),
    .o_div0(div0_1), .o_ovf(ovf1));

  qr_seq_divider #(.DW_A(27), .DW_B(27), .QW(16), .BPC(2)) u2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_signed(i_signed),
    .i_a(i_a), .i_b(i_b), .o_busy(busy2), .o_fin(fin2), .o_result(res2),
    .o_div0(div0_2), .o_ovf(ovf2));

  typedef struct {
    logic [26:0] a;
    logic [26:0] b;
    logic        s;
    logic [15:0] res;
    logic        div0;
    logic        ovf;
    int          lat1;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, then the clamping rules.
  function automatic void model(input logic [26:0] a, input logic [26:0] b, input logic s,
                                output logic [15:0] r, output logic d0, output logic ov,
                                output int lat);
    longint av, bv, aa, bb, q;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    d0 = 1'b0;
    ov = 1'b0;
    r  = '0;
    if (bv == 0) begin
      d0  = 1'b1;
      lat = 2;
      r   = !s ? 16'hFFFF : (av < 0 ? 16'h8000 : 16'h7FFF);
      return;
    end
    aa = (av < 0) ? -av : av;
    bb = (bv < 0) ? -bv : bv;
    q  = av / bv;
    lat = (aa >= bb * 65536) ? 2 : 18;
    if (s) begin
      if (q > 32767)       begin r = 16'h7FFF; ov = 1'b1; end
      else if (q < -32768) begin r = 16'h8000; ov = 1'b1; end
      else                 r = q[15:0];
    end else begin
      if (q > 65535) begin r = 16'hFFFF; ov = 1'b1; end
      else           r = q[15:0];
    end
  endfunction

  // Launch one request and capture each instance's first o_fin.
  task automatic do_op(input logic [26:0] a, input logic [26:0] b, input logic s,
                       output logic [15:0] r1, output logic [15:0] r2,
                       output logic [1:0] f1, output logic [1:0] f2,
                       output int l1, output int l2);
    l1 = -1; l2 = -1; r1 = 'x; r2 = 'x; f1 = 'x; f2 = 'x;
    @(negedge i_clk);
    i_a = a; i_b = b; i_signed = s; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (int n = 1; n <= 40 && (l1 < 0 || l2 < 0); n++) begin
      @(posedge i_clk);
      #1;
      if (fin1 && l1 < 0) begin l1 = n; r1 = res1; f1 = {div0_1, ovf1}; end
      if (fin2 && l2 < 0) begin l2 = n; r2 = res2; f2 = {div0_2, ovf2}; end
    end
  endtask

  task automatic check_op(input string tag, input logic [26:0] a, input logic [26:0] b,
                          input logic s, input logic [15:0] er, input logic [1:0] ef,
                          input int el1);
    logic [15:0] r1, r2;
    logic [1:0]  f1, f2;
    int          l1, l2, el2;
    el2 = (el1 == 2) ? 2 : 10;
    do_op(a, b, s, r1, r2, f1, f2, l1, l2);
    chk({tag, " res_bpc1"}, 32'(r1), 32'(er));
    chk({tag, " flags_bpc1"}, 32'(f1), 32'(ef));
    chk({tag, " lat_bpc1"}, 32'(l1), 32'(el1));
    chk({tag, " res_bpc2"}, 32'(r2), 32'(er));
    chk({tag, " flags_bpc2"}, 32'(f2), 32'(ef));
    chk({tag, " lat_bpc2"}, 32'(l2), 32'(el2));
  endtask

  initial begin
    logic [15:0] mr;
    logic        md0, mov;
    int          ml;
    int          fc1, fc2;
    logic [15:0] last1;
    logic [26:0] ra, rb;
    logic        rs;

    vecs[0]  = '{27'd1000,           27'd7,        1'b1, 16'h008E, 1'b0, 1'b0, 18};
    vecs[1]  = '{27'(-1000),         27'd7,        1'b1, 16'hFF72, 1'b0, 1'b0, 18};
    vecs[2]  = '{27'd1000,           27'(-7),      1'b1, 16'hFF72, 1'b0, 1'b0, 18};
    vecs[3]  = '{27'(-32768),        27'd1,        1'b1, 16'h8000, 1'b0, 1'b0, 18};
    vecs[4]  = '{27'(-5),            27'd0,        1'b1, 16'h8000, 1'b1, 1'b0, 2};
    vecs[5]  = '{27'd5,              27'd0,        1'b0, 16'hFFFF, 1'b1, 1'b0, 2};
    vecs[6]  = '{27'd1048576,        27'd1,        1'b1, 16'h7FFF, 1'b0, 1'b1, 2};
    vecs[7]  = '{27'd40000,          27'd1,        1'b1, 16'h7FFF, 1'b0, 1'b1, 18};
    vecs[8]  = '{27'd65535,          27'd1,        1'b0, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[9]  = '{27'd65536,          27'd1,        1'b0, 16'hFFFF, 1'b0, 1'b1, 2};
    vecs[10] = '{27'd0,              27'd5,        1'b1, 16'h0000, 1'b0, 1'b0, 18};
    vecs[11] = '{27'h4000000,        27'h7FFFFFF,  1'b1, 16'h7FFF, 1'b0, 1'b1, 2};
    vecs[12] = '{27'h7FFFFFF,        27'h7FFFFFF,  1'b0, 16'h0001, 1'b0, 1'b0, 18};
    vecs[13] = '{27'd0,              27'd0,        1'b1, 16'h7FFF, 1'b1, 1'b0, 2};

    // reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_bpc1", {25'd0, busy1, fin1, div0_1, ovf1, 3'd0}, 32'd0);
    chk("reset_res_bpc1", 32'(res1), 32'd0);
    chk("reset_bpc2", {25'd0, busy2, fin2, div0_2, ovf2, 3'd0}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // directed table
    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
               vecs[i].res, {vecs[i].div0, vecs[i].ovf}, vecs[i].lat1);

    // flags remain readable after o_fin drops
    repeat (3) @(posedge i_clk);
    #1;
    chk("hold_div0", {30'd0, div0_1, fin1}, 32'h2);
    chk("hold_res", 32'(res1), 32'h7FFF);

    // i_start while busy is ignored
    fc1 = 0; fc2 = 0; last1 = '0;
    @(negedge i_clk);
    i_a = 27'd1000; i_b = 27'd7; i_signed = 1'b1; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge i_clk);
      i_start = (n == 5);
      if (n == 5) i_a = 27'd50;
      @(posedge i_clk);
      #1;
      if (n == 3) chk("busy_mid", {30'd0, busy1, busy2}, 32'h3);
      if (fin1) begin fc1++; last1 = res1; end
      if (fin2) fc2++;
    end
    i_start = 1'b0;
    chk("ignore_fin_bpc1", 32'(fc1), 32'd1);
    chk("ignore_fin_bpc2", 32'(fc2), 32'd1);
    chk("ignore_res", 32'(last1), 32'h008E);

    // reset in the middle of ITER
    @(negedge i_clk);
    i_a = 27'd1000; i_b = 27'd7; i_signed = 1'b1; i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("midrst_bpc1", {res1, 12'd0, busy1, fin1, div0_1, ovf1}, 32'd0);
    chk("midrst_bpc2", {res2, 12'd0, busy2, fin2, div0_2, ovf2}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    fc1 = 0; fc2 = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge i_clk);
      #1;
      if (fin1) fc1++;
      if (fin2) fc2++;
    end
    chk("midrst_nofin", 32'(fc1 + fc2), 32'd0);

    // new request after reset completes normally
    check_op("postrst", 27'(-1000), 27'd7, 1'b1, 16'hFF72, 2'b00, 18);

    // randomized against the reference model
    for (int k = 0; k < 40; k++) begin
      ra = 27'($urandom) >> $urandom_range(0, 26);
      rb = 27'($urandom) >> $urandom_range(0, 26);
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) rb = '0;
      if (rs && $urandom_range(0, 1) == 1) ra = -ra;
      if (rs && $urandom_range(0, 1) == 1) rb = -rb;
      model(ra, rb, rs, mr, md0, mov, ml);
      check_op($sformatf("rnd%0d", k), ra, rb, rs, mr, {md0, mov}, ml);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qr_seq_divider.md
Name: qr_seq_divider

Overview:
- Parametrised, multi-cycle fixed-point divider for the QR datapath.
- Successor to the single-configuration divider used for Gram-Schmidt normalisation.
- Adds configurable operand and quotient widths, runtime signed/unsigned mode, radix-2 or radix-4 iteration, saturation, and divide-by-zero and overflow flags.
- Sits between the norm/inner-product stage and the R/Q register files; one division in flight at a time.

Parameters:
- DW_A, 27, dividend width (two's complement in signed mode).
- DW_B, 27, divisor width.
- QW, 16, quotient width. Must satisfy QW % BPC == 0.
- BPC, 1, quotient bits resolved per cycle. Legal values: 1 or 2.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  request pulse; sampled only in IDLE.
- i_signed  input  1  1 = operands and result are two's complement; 0 = unsigned. Sampled with i_start.
- i_a  input  DW_A  dividend. Sampled with i_start.
- i_b  input  DW_B  divisor. Sampled with i_start.
- o_busy  output  1  high from the cycle after acceptance until o_fin.
- o_fin  output  1  one-cycle pulse; result valid.
- o_result  output  QW  quotient, truncated toward zero and saturated.
- o_div0  output  1  with o_fin: divisor was zero.
- o_ovf  output  1  with o_fin: result was saturated, excluding the divide-by-zero case.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state IDLE; o_busy, o_fin, o_div0, o_ovf = 0; o_result = 0; all internal registers = 0.
- Reset mid-operation: abort immediately, return to IDLE, no o_fin is produced.
- State IDLE: if i_start=1, latch i_a, i_b, i_signed and go to PREP. o_busy rises on the next cycle.
- State PREP (1 cycle):
  - Form |a| and |b|; |b| is taken only in signed mode.
  - Record neg = sign(a) XOR sign(b), signed mode only.
  - If |b| == 0, set div0 and go to POST.
  - Else if |a| >= (|b| << QW), set ovf and go to POST.
  - Otherwise load the remainder with |a| and go to ITER.
- Internal width: comparisons use DW_A+1 bits to hold |most-negative| and DW_B+QW+1 bits for the shifted divisor. No truncation is permitted.
- State ITER (QW/BPC cycles):
  - Restoring division, MSB first.
  - Each cycle resolves BPC quotient bits by comparing the remainder against (|b| << k) for k from QW-1 down to 0.
  - BPC=2 uses three parallel comparisons against 1x, 2x and 3x the shifted divisor.
  - After the last cycle, go to POST.
- State POST (1 cycle): form the result.
  - Normal path: apply sign if neg, then saturate.
    - Signed: clamp to [-2^(QW-1), 2^(QW-1)-1]; set ovf if clamped.
    - Unsigned: magnitude is at most 2^QW-1 by construction.
  - div0 result: signed with a >= 0 gives 2^(QW-1)-1; signed with a < 0 gives -2^(QW-1); unsigned gives all ones.
  - ovf-from-PREP result: same saturated extreme as div0, chosen by sign(neg).
  - Register o_result, o_div0, o_ovf. Pulse o_fin the next cycle, drop o_busy, return to IDLE.
- Latency (accepting edge to o_fin high):
  - Normal path: QW/BPC + 2 edges. Defaults: 18 edges for BPC=1, 10 for BPC=2.
  - div0 and PREP-overflow path: 2 edges.
- Handshake:
  - i_start while o_busy=1 is ignored; there is no queueing.
  - i_start held high in IDLE on the same cycle o_fin pulses is accepted; back-to-back throughput is one result per latency+1 cycles.
- Output hold: o_result, o_div0 and o_ovf hold their values until the next POST. o_div0 and o_ovf remain readable after o_fin falls.
- Zero dividend: normal path, result 0, no flags.

Test Plan (QW=16, DW_A=DW_B=27, BPC=1 unless stated):
- Signed a=1000, b=7 -> o_result=142 (0x008E), o_fin exactly 18 edges after acceptance, flags 0. Repeat with BPC=2 -> same result at 10 edges.
- Signed a=-1000, b=7 -> 0xFF72 (-142, truncated toward zero). Signed a=1000, b=-7 -> 0xFF72. Signed a=-32768, b=1 -> 0x8000, o_ovf=0.
- Signed a=-5, b=0 -> 0x8000, o_div0=1, o_fin at 2 edges. Unsigned a=5, b=0 -> 0xFFFF, o_div0=1.
- Signed a=2^20, b=1 -> 0x7FFF, o_ovf=1, o_fin at 2 edges. Signed a=40000, b=1 -> normal path, 0x7FFF, o_ovf=1 set in POST.
- Unsigned a=65535, b=1 -> 0xFFFF, o_ovf=0. Unsigned a=65536, b=1 -> 0xFFFF, o_ovf=1.
- Control:
  - i_start pulsed at cycle 5 of a busy operation -> ignored; only one o_fin.
  - i_rst asserted at cycle 8 of ITER -> all outputs 0 immediately, no o_fin.
  - A new i_start after reset completes normally.
